// File: rtl/gate_selftest_pkg.sv
// Shared types and constants for the gate self-test block: FSM states,
// vector count and reference truth tables indexed by {a,b}.
package gate_tb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int NVEC = 4;
  localparam logic [1:0] LAST_VEC = 2'(NVEC - 1);

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_selftest_if.sv
// Signal bundle between the self-test engine (master) and its environment
// (slave: start request, gate response y, result observation).
interface gate_selftest_if;
  import gate_tb_pkg::*;

  // start is level-sampled; it is only accepted on an edge where the engine
  // is idle, so no ready signal exists -- busy/done report progress instead.
  logic       start;
  logic       a;
  logic       b;
  logic       y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;
  logic       fail_valid;
  state_t     dbg_state;

  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_cnt, fail_vec, fail_valid, dbg_state
  );

  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_cnt, fail_vec, fail_valid, dbg_state
  );

endinterface

// File: rtl/gate_selftest_hold_timer.sv
// Per-vector settle counter: loads a value, counts down to zero and holds
// there, flagging zero so the engine knows when to sample the gate.
module hold_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_selftest.sv
// Gate self-test engine: steps {a,b} through 00..11, holds each vector
// SETTLE+1 cycles, compares y to EXP_TT and reports pass/error statistics.
module gate_selftest
  import gate_tb_pkg::*;
#(
  parameter logic [3:0]  EXP_TT = TT_AND,
  parameter int unsigned SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  gate_selftest_if.master bus
);

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [1:0] fvec_q, fvec_d;
  logic       fv_q, fv_d;

  logic       load;
  logic       zero;
  logic       mism;
  logic [2:0] err_next;

  hold_timer u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (SETTLE_V),
    .zero_o     (zero)
  );

  assign mism     = (bus.y != EXP_TT[k_q]);
  assign err_next = err_q + {2'b00, mism};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fv_d    = fv_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = HOLD;
          k_d        = 2'd0;
          {a_d, b_d} = 2'b00;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          err_d      = 3'd0;
          fvec_d     = 2'b00;
          fv_d       = 1'b0;
          load       = 1'b1;
        end
      end
      HOLD: begin
        if (zero) begin
          err_d = err_next;
          if (mism && !fv_q) begin
            fv_d   = 1'b1;
            fvec_d = k_q;
          end
          // The sampling edge of the last vector also publishes the verdict,
          // so pass must see this edge's mismatch via err_next.
          if (k_q == LAST_VEC) begin
            state_d    = FINISH;
            {a_d, b_d} = 2'b00;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            pass_d     = (err_next == 3'd0);
          end else begin
            k_d        = k_q + 2'd1;
            {a_d, b_d} = k_q + 2'd1;
            load       = 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fvec_q  <= 2'b00;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.fail_vec   = fvec_q;
  assign bus.fail_valid = fv_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_gate_selftest.sv
// Bench for gate_selftest: two instances (AND/SETTLE=2 and OR/SETTLE=0),
// a run-offset based reference model, directed runs and random traffic.
module tb_gate_selftest;
  import gate_tb_pkg::*;

  localparam int S0 = 2;
  localparam int S1 = 0;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   mode[2];
  bit   done_seen0;

  gate_selftest_if ifc0 ();
  gate_selftest_if ifc1 ();

  gate_selftest #(.EXP_TT(TT_AND), .SETTLE(S0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifc0)
  );

  gate_selftest #(.EXP_TT(TT_OR), .SETTLE(S1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1)
  );

  // 0 AND, 1 OR, 2 XOR, 3 NAND, 4 tie-0, 5 tie-1
  function automatic logic gate_fn(int md, logic a, logic b);
    case (md)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      3:       return ~(a & b);
      4:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign ifc0.y = gate_fn(mode[0], ifc0.a, ifc0.b);
  assign ifc1.y = gate_fn(mode[1], ifc1.a, ifc1.b);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // A run accepted at edge E0 is described purely by its offset from E0:
  // vector = off / (SETTLE+1), samples land on multiples of SETTLE+1.
  int         per[2];
  logic [3:0] m_exp[2];
  bit         m_run[2];
  bit         m_fin[2];
  int         m_e0[2];
  logic       m_a[2], m_b[2], m_busy[2], m_done[2], m_pass[2], m_fv[2];
  logic [2:0] m_err[2];
  logic [1:0] m_fvec[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i]  = 0;
      m_fin[i]  = 0;
      m_e0[i]   = 0;
      m_a[i]    = 0;
      m_b[i]    = 0;
      m_busy[i] = 0;
      m_done[i] = 0;
      m_pass[i] = 0;
      m_fv[i]   = 0;
      m_err[i]  = 3'd0;
      m_fvec[i] = 2'd0;
    end
  endtask

  task automatic model_edge(int i, logic st);
    logic yv;
    int   off;
    int   k;
    int   vec;
    yv = gate_fn(mode[i], m_a[i], m_b[i]);
    m_done[i] = 0;
    if (m_run[i]) begin
      off = cyc - m_e0[i];
      if (off % per[i] == 0) begin
        k = off / per[i] - 1;
        if (yv !== m_exp[i][k]) begin
          m_err[i] = m_err[i] + 3'd1;
          if (!m_fv[i]) begin
            m_fv[i]   = 1;
            m_fvec[i] = 2'(k);
          end
        end
        if (k == NVEC - 1) begin
          m_run[i]  = 0;
          m_fin[i]  = 1;
          m_done[i] = 1;
          m_busy[i] = 0;
          m_pass[i] = (m_err[i] == 3'd0);
        end
      end
      if (m_run[i]) begin
        vec = off / per[i];
        m_a[i] = vec[1];
        m_b[i] = vec[0];
      end else begin
        m_a[i] = 0;
        m_b[i] = 0;
      end
    end else if (m_fin[i]) begin
      m_fin[i] = 0;
    end else if (st) begin
      m_run[i]  = 1;
      m_e0[i]   = cyc;
      m_a[i]    = 0;
      m_b[i]    = 0;
      m_busy[i] = 1;
      m_err[i]  = 3'd0;
      m_pass[i] = 0;
      m_fv[i]   = 0;
      m_fvec[i] = 2'd0;
    end
  endtask

  initial begin
    per[0]   = S0 + 1;
    per[1]   = S1 + 1;
    m_exp[0] = TT_AND;
    m_exp[1] = TT_OR;
    model_reset();
  end

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      model_edge(0, ifc0.start);
      model_edge(1, ifc1.start);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_inst(int i, logic a, logic b, logic busy, logic done, logic pass,
                          logic [2:0] err, logic [1:0] fvec, logic fv);
    check($sformatf("i%0d_a", i), 8'(a), 8'(m_a[i]));
    check($sformatf("i%0d_b", i), 8'(b), 8'(m_b[i]));
    check($sformatf("i%0d_busy", i), 8'(busy), 8'(m_busy[i]));
    check($sformatf("i%0d_done", i), 8'(done), 8'(m_done[i]));
    check($sformatf("i%0d_pass", i), 8'(pass), 8'(m_pass[i]));
    check($sformatf("i%0d_err_cnt", i), 8'(err), 8'(m_err[i]));
    check($sformatf("i%0d_fail_vec", i), 8'(fvec), 8'(m_fvec[i]));
    check($sformatf("i%0d_fail_valid", i), 8'(fv), 8'(m_fv[i]));
  endtask

  always @(negedge clk) begin
    if (ifc0.done) done_seen0 = 1;
    cmp_inst(0, ifc0.a, ifc0.b, ifc0.busy, ifc0.done, ifc0.pass,
             ifc0.err_cnt, ifc0.fail_vec, ifc0.fail_valid);
    cmp_inst(1, ifc1.a, ifc1.b, ifc1.busy, ifc1.done, ifc1.pass,
             ifc1.err_cnt, ifc1.fail_vec, ifc1.fail_valid);
  end

  // ---------------- driver helpers ----------------
  task automatic set_start(int i, logic v);
    if (i == 0) ifc0.start = v;
    else        ifc1.start = v;
  endtask

  function automatic logic [7:0] res_of(int i, int sel);
    if (i == 0) begin
      case (sel)
        0: return 8'(ifc0.done);
        1: return 8'(ifc0.pass);
        2: return 8'(ifc0.err_cnt);
        3: return 8'(ifc0.fail_vec);
        default: return 8'(ifc0.fail_valid);
      endcase
    end else begin
      case (sel)
        0: return 8'(ifc1.done);
        1: return 8'(ifc1.pass);
        2: return 8'(ifc1.err_cnt);
        3: return 8'(ifc1.fail_vec);
        default: return 8'(ifc1.fail_valid);
      endcase
    end
  endfunction

  // One run with hand-computed expectations for the result registers.
  task automatic run_one(int i, bit repulse, int exp_off, logic exp_pass,
                         logic [2:0] exp_err, logic [1:0] exp_fvec, logic exp_fv);
    int e0;
    bit seen;
    set_start(i, 1'b1);
    e0 = cyc + 1;
    @(negedge clk);
    set_start(i, 1'b0);
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (res_of(i, 0) == 8'd1) begin
        seen = 1;
      end else begin
        set_start(i, (repulse && cyc == e0 + 3) ? 1'b1 : 1'b0);
        @(negedge clk);
      end
    end
    set_start(i, 1'b0);
    check($sformatf("i%0d_done_seen", i), 8'(seen), 8'd1);
    check($sformatf("i%0d_done_offset", i), 8'(cyc - e0), 8'(exp_off));
    check($sformatf("i%0d_lit_pass", i), res_of(i, 1), 8'(exp_pass));
    check($sformatf("i%0d_lit_err", i), res_of(i, 2), 8'(exp_err));
    check($sformatf("i%0d_lit_fvec", i), res_of(i, 3), 8'(exp_fvec));
    check($sformatf("i%0d_lit_fvalid", i), res_of(i, 4), 8'(exp_fv));
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cyc        = 0;
    total      = 0;
    bad        = 0;
    done_seen0 = 0;
    mode[0]    = 0;
    mode[1]    = 1;
    rst        = 1'b1;
    ifc0.start = 1'b0;
    ifc1.start = 1'b0;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 5; s++) check("reset_lit", res_of(0, s), 8'd0);
    check("reset_busy", 8'(ifc0.busy), 8'd0);
    check("reset_ab", 8'({ifc0.a, ifc0.b}), 8'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Correct AND gate with a start re-pulse while busy, then OR at SETTLE=0.
    run_one(0, 1'b1, 12, 1'b1, 3'd0, 2'd0, 1'b0);
    run_one(1, 1'b0, 4, 1'b1, 3'd0, 2'd0, 1'b0);

    mode[0] = 4;   // y stuck at 0
    run_one(0, 1'b0, 12, 1'b0, 3'd1, 2'd3, 1'b1);
    mode[0] = 5;   // y stuck at 1
    run_one(0, 1'b0, 12, 1'b0, 3'd3, 2'd0, 1'b1);
    mode[0] = 3;   // NAND against AND expectation
    run_one(0, 1'b0, 12, 1'b0, 3'd4, 2'd0, 1'b1);
    mode[1] = 2;   // XOR against OR expectation: only vector 11 differs
    run_one(1, 1'b0, 4, 1'b0, 3'd1, 2'd3, 1'b1);

    // Reset mid-run: immediate clear, no done pulse, clean rerun afterwards.
    mode[0] = 0;
    mode[1] = 1;
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (5) @(negedge clk);
    done_seen0 = 0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    for (int s = 0; s < 5; s++) check("abort_lit", res_of(0, s), 8'd0);
    check("abort_busy", 8'(ifc0.busy), 8'd0);
    check("abort_ab", 8'({ifc0.a, ifc0.b}), 8'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_no_done", 8'(done_seen0), 8'd0);
    run_one(0, 1'b0, 12, 1'b1, 3'd0, 2'd0, 1'b0);

    // start held high: back-to-back runs re-trigger from IDLE.
    set_start(0, 1'b1);
    set_start(1, 1'b1);
    repeat (40) @(negedge clk);
    set_start(0, 1'b0);
    set_start(1, 1'b0);

    // Random traffic checked cycle by cycle against the model.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 15) == 0) mode[i] = $urandom_range(0, 5);
        set_start(i, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    set_start(0, 1'b0);
    set_start(1, 1'b0);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
